life_run_controller: RTL and testbench

//  Sequences the Game-of-Life grid datapath from debounced one-cycle button-release pulses.

---
 rtl/life_run_controller_if.sv | 48 ++++
 rtl/life_run_controller.sv | 171 +++++++++++++++++
 tb/tb_life_run_controller.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/life_run_controller_if.sv
// Handshake bundle between the button pulse logic, the run controller and the grid engine.
// Optional speedSel signal present only when SPEED_SEL_EN is defined.
interface life_run_controller_if #(
  parameter int unsigned GEN_W = 16
);
  logic             startStopPulse;
  logic             stepPulse;
  logic             clearPulse;
  logic             gridDone;
`ifdef SPEED_SEL_EN
  logic [1:0]       speedSel;
`endif
  logic             stepGo;
  logic             clearGo;
  logic             running;
  logic             busy;
  logic [GEN_W-1:0] genCount;

  modport master (
`ifdef SPEED_SEL_EN
    output speedSel,
`endif
    output startStopPulse,
    output stepPulse,
    output clearPulse,
    output gridDone,
    input  stepGo,
    input  clearGo,
    input  running,
    input  busy,
    input  genCount
  );

  modport slave (
`ifdef SPEED_SEL_EN
    input  speedSel,
`endif
    input  startStopPulse,
    input  stepPulse,
    input  clearPulse,
    input  gridDone,
    output stepGo,
    output clearGo,
    output running,
    output busy,
    output genCount
  );
endinterface

// File: rtl/life_run_controller.sv
// Pause / single-step / free-run / clear sequencer for the Game-of-Life grid engine.
// Define SPEED_SEL_EN to add the speedSel period divider on the interface.
module life_run_controller #(
  parameter int unsigned GEN_PERIOD = 25_000_000,
  parameter int unsigned CNT_W      = 25,
  parameter int unsigned GEN_W      = 16
) (
  input logic                 clk,
  input logic                 reset,
  life_run_controller_if.slave bus
);

  typedef enum logic [2:0] {
    StPaused,
    StRunWait,
    StRunBusy,
    StStepBusy,
    StClrBusy
  } state_e;

  localparam logic [CNT_W-1:0] FullPeriod = CNT_W'(GEN_PERIOD);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             stop_pend_q, stop_pend_d;
  logic             clr_pend_q, clr_pend_d;
  logic             hold_ss_q, hold_ss_d;
  logic             hold_step_q, hold_step_d;
  logic             hold_clr_q, hold_clr_d;
  logic             step_go_q, step_go_d;
  logic             clear_go_q, clear_go_d;
  logic             running_q, running_d;
  logic             busy_q, busy_d;

  logic             issue_step, issue_clear;
  logic             ss_eff, step_eff, clr_eff;
  logic [CNT_W-1:0] sel_period;

  // Pulses arriving with a done are replayed next cycle against the post-done state.
  assign ss_eff   = bus.startStopPulse | hold_ss_q;
  assign step_eff = bus.stepPulse      | hold_step_q;
  assign clr_eff  = bus.clearPulse     | hold_clr_q;

`ifdef SPEED_SEL_EN
  logic [CNT_W-1:0] shifted_period;
  assign shifted_period = FullPeriod >> {bus.speedSel, 1'b0};
  assign sel_period     = (shifted_period < CNT_W'(2)) ? CNT_W'(2) : shifted_period;
`else
  assign sel_period = FullPeriod;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StPaused;
      timer_q     <= '0;
      period_q    <= FullPeriod;
      gen_q       <= '0;
      stop_pend_q <= 1'b0;
      clr_pend_q  <= 1'b0;
      hold_ss_q   <= 1'b0;
      hold_step_q <= 1'b0;
      hold_clr_q  <= 1'b0;
      step_go_q   <= 1'b0;
      clear_go_q  <= 1'b0;
      running_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      period_q    <= period_d;
      gen_q       <= gen_d;
      stop_pend_q <= stop_pend_d;
      clr_pend_q  <= clr_pend_d;
      hold_ss_q   <= hold_ss_d;
      hold_step_q <= hold_step_d;
      hold_clr_q  <= hold_clr_d;
      step_go_q   <= step_go_d;
      clear_go_q  <= clear_go_d;
      running_q   <= running_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    period_d    = period_q;
    gen_d       = gen_q;
    stop_pend_d = stop_pend_q;
    clr_pend_d  = clr_pend_q;
    hold_ss_d   = 1'b0;
    hold_step_d = 1'b0;
    hold_clr_d  = 1'b0;
    issue_step  = 1'b0;
    issue_clear = 1'b0;

    unique case (state_q)
      StPaused: begin
        if (clr_eff) begin
          state_d     = StClrBusy;
          issue_clear = 1'b1;
        end else if (ss_eff) begin
          state_d    = StRunBusy;
          issue_step = 1'b1;
        end else if (step_eff) begin
          state_d    = StStepBusy;
          issue_step = 1'b1;
        end
      end

      StRunWait: begin
        if (clr_eff) begin
          state_d     = StClrBusy;
          issue_clear = 1'b1;
          timer_d     = '0;
        end else if (ss_eff) begin
          state_d = StPaused;
          timer_d = '0;
        end else if (timer_q == period_q - 1'b1) begin
          state_d    = StRunBusy;
          issue_step = 1'b1;
          timer_d    = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      StRunBusy, StStepBusy, StClrBusy: begin
        if (bus.gridDone) begin
          hold_ss_d   = ss_eff;
          hold_step_d = step_eff;
          hold_clr_d  = clr_eff;
          stop_pend_d = 1'b0;
          clr_pend_d  = 1'b0;
          gen_d       = (state_q == StClrBusy) ? '0 : gen_q + 1'b1;
          if (clr_pend_q) begin
            state_d     = StClrBusy;
            issue_clear = 1'b1;
          end else if (state_q == StRunBusy && !stop_pend_q) begin
            state_d  = StRunWait;
            timer_d  = '0;
            period_d = sel_period;
          end else begin
            state_d = StPaused;
          end
        end else begin
          if (clr_eff) clr_pend_d = 1'b1;
          if (ss_eff && state_q == StRunBusy) stop_pend_d = ~stop_pend_q;
        end
      end

      default: state_d = StPaused;
    endcase
  end

  always_comb begin
    step_go_d  = issue_step;
    clear_go_d = issue_clear;
    running_d  = (state_d == StRunWait) || (state_d == StRunBusy);
    busy_d     = (state_d == StRunBusy) || (state_d == StStepBusy) || (state_d == StClrBusy);
  end

  assign bus.stepGo   = step_go_q;
  assign bus.clearGo  = clear_go_q;
  assign bus.running  = running_q;
  assign bus.busy     = busy_q;
  assign bus.genCount = gen_q;

endmodule

// File: tb/tb_life_run_controller.sv
// Bench for life_run_controller: directed vector table, hand sequences and a random run
// checked cycle by cycle against an event-level model of the controller.
module tb_life_run_controller;

`ifdef SPEED_SEL_EN
  localparam int unsigned GenPeriod = 64;
  localparam int unsigned CntW      = 7;
`else
  localparam int unsigned GenPeriod = 4;
  localparam int unsigned CntW      = 3;
`endif
  localparam int unsigned GenW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  life_run_controller_if #(.GEN_W(GenW)) bus ();

  life_run_controller #(
    .GEN_PERIOD(GenPeriod),
    .CNT_W     (CntW),
    .GEN_W     (GenW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int gcd      = -1;  // grid model countdown to its done pulse, -1 when idle

  // Model: run mode flag, outstanding operation (0 none, 1 generation, 2 clear), wait countdown.
  bit             m_run, m_stop, m_clr, h_ss, h_st, h_cl, m_sg, m_cg;
  int             m_op, m_wait;
  logic [GenW-1:0] m_gen;

  typedef struct {
    logic [3:0] in;     // {startStop, step, clear, gridDone}
    logic [3:0] flags;  // {stepGo, clearGo, running, busy}
    logic [3:0] gen;
  } vec_t;
  vec_t tbl[28];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int cur_sel();
`ifdef SPEED_SEL_EN
    return int'(bus.speedSel);
`else
    return 0;
`endif
  endfunction

  function automatic int eff_period(input int sel);
    int p = int'(GenPeriod) / (1 << (2 * sel));
    if (p < 2) p = 2;
    return p;
  endfunction

  task automatic model_reset();
    m_run = 0; m_stop = 0; m_clr = 0; h_ss = 0; h_st = 0; h_cl = 0;
    m_sg = 0; m_cg = 0; m_op = 0; m_wait = 0; m_gen = '0;
  endtask

  task automatic model_step(input bit ss, input bit st, input bit cl, input bit dn);
    bit es = ss | h_ss;
    bit et = st | h_st;
    bit ec = cl | h_cl;
    h_ss = 0; h_st = 0; h_cl = 0; m_sg = 0; m_cg = 0;
    if (m_op != 0) begin
      if (dn) begin
        h_ss = es; h_st = et; h_cl = ec;
        if (m_op == 1) m_gen = m_gen + 1'b1;
        else m_gen = '0;
        if (m_clr) begin
          m_op = 2; m_run = 0; m_cg = 1;
        end else if (m_op == 1 && m_run && !m_stop) begin
          m_op = 0; m_wait = eff_period(cur_sel());
        end else begin
          m_op = 0; m_run = 0;
        end
        m_clr = 0; m_stop = 0;
      end else begin
        if (ec) m_clr = 1;
        if (es && m_op == 1 && m_run) m_stop = !m_stop;
      end
    end else if (m_run) begin
      if (ec) begin
        m_run = 0; m_op = 2; m_cg = 1;
      end else if (es) begin
        m_run = 0;
      end else if (m_wait <= 1) begin
        m_op = 1; m_sg = 1;
      end else begin
        m_wait--;
      end
    end else begin
      if (ec) begin
        m_op = 2; m_cg = 1;
      end else if (es) begin
        m_run = 1; m_op = 1; m_sg = 1;
      end else if (et) begin
        m_op = 1; m_sg = 1;
      end
    end
  endtask

  function automatic int dut_vec();
    return int'({bus.stepGo, bus.clearGo, bus.running, bus.busy, bus.genCount});
  endfunction

  function automatic int model_vec();
    return int'({m_sg, m_cg, m_run, (m_op != 0), m_gen});
  endfunction

  task automatic drive(input bit ss, input bit st, input bit cl, input bit dn);
    bus.startStopPulse = ss;
    bus.stepPulse      = st;
    bus.clearPulse     = cl;
    bus.gridDone       = dn;
    @(posedge clk);
    model_step(ss, st, cl, dn);
    cyc++;
    if (gcd >= 0) gcd--;
    if (m_sg || m_cg) gcd = 2;
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  task automatic drive_auto(input bit ss, input bit st, input bit cl);
    drive(ss, st, cl, gcd == 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.startStopPulse = 1'b0;
    bus.stepPulse      = 1'b0;
    bus.clearPulse     = 1'b0;
    bus.gridDone       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    gcd = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int any_go, dones, last_go, gap_done, found;
`ifdef SPEED_SEL_EN
    bus.speedSel = 2'd2;
`endif
    tbl[0]  = '{4'b0100, 4'b1001, 4'd0};
    tbl[1]  = '{4'b0100, 4'b0001, 4'd0};
    tbl[2]  = '{4'b0000, 4'b0001, 4'd0};
    tbl[3]  = '{4'b0001, 4'b0000, 4'd1};
    tbl[4]  = '{4'b1010, 4'b0101, 4'd1};
    tbl[5]  = '{4'b0000, 4'b0001, 4'd1};
    tbl[6]  = '{4'b0000, 4'b0001, 4'd1};
    tbl[7]  = '{4'b0001, 4'b0000, 4'd0};
    tbl[8]  = '{4'b0001, 4'b0000, 4'd0};
    tbl[9]  = '{4'b1000, 4'b1011, 4'd0};
    tbl[10] = '{4'b1000, 4'b0011, 4'd0};
    tbl[11] = '{4'b0000, 4'b0011, 4'd0};
    tbl[12] = '{4'b0001, 4'b0000, 4'd1};
    tbl[13] = '{4'b1000, 4'b1011, 4'd1};
    tbl[14] = '{4'b0010, 4'b0011, 4'd1};
    tbl[15] = '{4'b0000, 4'b0011, 4'd1};
    tbl[16] = '{4'b0001, 4'b0101, 4'd2};
    tbl[17] = '{4'b0000, 4'b0001, 4'd2};
    tbl[18] = '{4'b0000, 4'b0001, 4'd2};
    tbl[19] = '{4'b0001, 4'b0000, 4'd0};
    tbl[20] = '{4'b0100, 4'b1001, 4'd0};
    tbl[21] = '{4'b0000, 4'b0001, 4'd0};
    tbl[22] = '{4'b1001, 4'b0000, 4'd1};
    tbl[23] = '{4'b0000, 4'b1011, 4'd1};
    tbl[24] = '{4'b0000, 4'b0011, 4'd1};
    tbl[25] = '{4'b0000, 4'b0011, 4'd1};
    tbl[26] = '{4'b1001, 4'b0010, 4'd2};
    tbl[27] = '{4'b0000, 4'b0000, 4'd2};

    // Reset and idle
    do_reset();
    check("reset_state", dut_vec(), 0);
    any_go = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      if (bus.stepGo || bus.clearGo || bus.running) any_go++;
    end
    check("idle_quiet", any_go, 0);

    // Directed vectors
    do_reset();
    for (int i = 0; i < 28; i++) begin
      drive(tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
      check($sformatf("vec%0d", i), dut_vec(), int'({tbl[i].flags, tbl[i].gen}));
    end

    // Free run: go-to-go interval, 16 generations wrap the counter
    do_reset();
    drive_auto(1'b1, 1'b0, 1'b0);
    check("run_first_go", int'({bus.stepGo, bus.running}), 3);
    last_go = cyc;
    dones = 0;
    for (int i = 0; i < 300 && dones < 16; i++) begin
      if (gcd == 0) dones++;
      drive_auto(1'b0, 1'b0, 1'b0);
      if (bus.stepGo) begin
        check("run_interval", cyc - last_go, 7);
        last_go = cyc;
      end
    end
    check("run_dones", dones, 16);
    check("gen_wrap", int'(bus.genCount), 0);

    // Stop requested while a generation is outstanding
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive_auto(1'b0, 1'b0, 1'b0);
      if (bus.stepGo) found = 1;
    end
    check("stop_go_seen", found, 1);
    drive_auto(1'b1, 1'b0, 1'b0);
    any_go = 0;
    for (int i = 0; i < 15; i++) begin
      drive_auto(1'b0, 1'b0, 1'b0);
      if (bus.stepGo) any_go++;
    end
    check("stop_no_go", any_go, 0);
    check("stop_state", dut_vec(), 1);

    // Reset mid-generation, then a late done
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_reset_busy", int'({bus.running, bus.busy}), 3);
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("late_done", dut_vec(), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("late_done_idle", dut_vec(), 0);

`ifdef SPEED_SEL_EN
    // Clamped period: speedSel=3 gives a 2-cycle wait
    do_reset();
    bus.speedSel = 2'd3;
    drive_auto(1'b1, 1'b0, 1'b0);
    gap_done = -1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (gcd == 0) gap_done = cyc;
      drive_auto(1'b0, 1'b0, 1'b0);
      if (bus.stepGo && gap_done >= 0) found = cyc - gap_done - 1;
    end
    check("speed3_gap", found, 2);
    drive_auto(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive_auto(1'b0, 1'b0, 1'b0);
    bus.speedSel = 2'd2;
`else
    gap_done = 0;
`endif

    // Random pulses against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit dn;
      dn = (gcd == 0) || (m_op == 0 && gcd < 0 && $urandom_range(0, 19) == 0);
`ifdef SPEED_SEL_EN
      if ($urandom_range(0, 63) == 0) bus.speedSel = 2'($urandom_range(1, 3));
`endif
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 40) == 0, dn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
